// File: rtl/mat_b_buffer_if.sv
// Load/read bus between the matrix B source, mat_b_buffer and the data extractor.
// The buffer sits on the slave side; the loader/extractor side uses master.
interface mat_b_buffer_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FIF0_DEPTH = 256
);
   localparam int unsigned AW = $clog2(FIF0_DEPTH);
   localparam int unsigned CW = AW + 1;

   logic                  start_load;
   logic [CW-1:0]         load_count;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_valid;
   logic                  wr_ready;
   logic [AW-1:0]         rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  load_done;
   logic                  load_err;
   logic [CW-1:0]         elem_count;

   modport master (
      output start_load, load_count, wr_data, wr_valid, rd_addr,
      input  wr_ready, rd_data, rd_valid, load_done, load_err, elem_count
   );

   modport slave (
      input  start_load, load_count, wr_data, wr_valid, rd_addr,
      output wr_ready, rd_data, rd_valid, load_done, load_err, elem_count
   );
endinterface

// File: rtl/mat_b_buffer.sv
// Matrix B staging buffer: loads a row-major matrix, then serves random reads
// with one-cycle latency and zero padding past the loaded element count.
module mat_b_buffer #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FIF0_DEPTH = 256
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          rst_flush,
   mat_b_buffer_if.slave bus
);
   localparam int unsigned AW = $clog2(FIF0_DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {IDLE, LOAD, SERVE} state_t;

   state_t                state;
   logic [CW-1:0]         load_len;
   logic [AW-1:0]         wr_ptr;
   logic [CW-1:0]         elem_count;
   logic                  wr_ready;
   logic                  rd_valid;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  load_done;
   logic                  load_err;

   logic [DATA_WIDTH-1:0] mem [FIF0_DEPTH];

   logic wr_fire_c;
   logic start_ok_c;
   logic last_c;

   // wr_ready is only ever high in LOAD, so it doubles as the write qualifier
   assign wr_fire_c  = wr_ready && bus.wr_valid && !rst_flush;
   assign start_ok_c = (bus.load_count != '0) && (bus.load_count <= CW'(FIF0_DEPTH));
   assign last_c     = (CW'(wr_ptr) == (load_len - CW'(1)));

   // Write port; contents are deliberately left unreset
   always_ff @(posedge clk) begin
      if (wr_fire_c) begin
         mem[wr_ptr] <= bus.wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         load_len   <= '0;
         wr_ptr     <= '0;
         elem_count <= '0;
         wr_ready   <= 1'b0;
         rd_valid   <= 1'b0;
         rd_data    <= '0;
         load_done  <= 1'b0;
         load_err   <= 1'b0;
      end else if (rst_flush) begin
         state      <= IDLE;
         load_len   <= '0;
         wr_ptr     <= '0;
         elem_count <= '0;
         wr_ready   <= 1'b0;
         rd_valid   <= 1'b0;
         rd_data    <= '0;
         load_done  <= 1'b0;
         load_err   <= 1'b0;
      end else begin
         load_done <= 1'b0;
         load_err  <= 1'b0;
         case (state)
            IDLE, SERVE: begin
               if (bus.start_load && start_ok_c) begin
                  state      <= LOAD;
                  load_len   <= bus.load_count;
                  wr_ptr     <= '0;
                  elem_count <= '0;
                  wr_ready   <= 1'b1;
                  rd_valid   <= 1'b0;
                  rd_data    <= '0;
               end else begin
                  load_err <= bus.start_load;
                  if (state == SERVE) begin
                     rd_valid <= 1'b1;
                     // Addresses past the loaded matrix read as zero padding
                     if (CW'(bus.rd_addr) < elem_count) begin
                        rd_data <= mem[bus.rd_addr];
                     end else begin
                        rd_data <= '0;
                     end
                  end else begin
                     rd_valid <= 1'b0;
                     rd_data  <= '0;
                  end
               end
            end
            LOAD: begin
               rd_valid <= 1'b0;
               rd_data  <= '0;
               if (wr_fire_c) begin
                  wr_ptr     <= wr_ptr + AW'(1);
                  elem_count <= elem_count + CW'(1);
                  if (last_c) begin
                     state     <= SERVE;
                     wr_ready  <= 1'b0;
                     load_done <= 1'b1;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               wr_ready <= 1'b0;
               rd_valid <= 1'b0;
               rd_data  <= '0;
            end
         endcase
      end
   end

   assign bus.wr_ready   = wr_ready;
   assign bus.rd_data    = rd_data;
   assign bus.rd_valid   = rd_valid;
   assign bus.load_done  = load_done;
   assign bus.load_err   = load_err;
   assign bus.elem_count = elem_count;

endmodule

// File: doc/mat_b_buffer.md
MAT_B_BUFFER -- requirements
Module: mat_b_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 32: element width in bits.
REQ-002 Parameter FIF0_DEPTH, default 256: buffer entries; AW = $clog2(FIF0_DEPTH).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rst_flush  input  1  synchronous flush, active-high.
REQ-006 start_load  input  1  single-cycle request to begin loading a new matrix B.
REQ-007 load_count  input  AW+1  number of elements to load; sampled when start_load is accepted.
REQ-008 wr_data  input  DATA_WIDTH  element, row-major.
REQ-009 wr_valid  input  1  wr_data valid.
REQ-010 wr_ready  output  1  buffer accepts wr_data this cycle.
REQ-011 rd_addr  input  AW  read address, driven by the matrix B data extractor's fifo_addr.
REQ-012 rd_data  output  DATA_WIDTH  read data, feeds the extractor's data_in.
REQ-013 rd_valid  output  1  rd_data valid, feeds the extractor's valid_in.
REQ-014 load_done  output  1  one-cycle pulse when the last element is written.
REQ-015 load_err  output  1  one-cycle pulse when start_load is rejected.
REQ-016 elem_count  output  AW+1  number of elements currently stored.

Function
REQ-017 The FSM SHALL have three states: IDLE, LOAD, SERVE; the reset state is IDLE.
REQ-018 In IDLE or SERVE, start_load=1 with 1 <= load_count <= FIF0_DEPTH SHALL move to LOAD next cycle, latch load_count, clear wr_ptr and elem_count.
REQ-019 start_load with load_count=0 or load_count > FIF0_DEPTH SHALL be rejected: state unchanged, load_err=1 for one cycle.
REQ-020 start_load in LOAD SHALL be ignored, with no error pulse.
REQ-021 wr_ready SHALL be 1 only in LOAD, as a registered state decode, with no combinational path from wr_valid.
REQ-022 A transfer occurs when wr_valid and wr_ready are both 1: write mem[wr_ptr]=wr_data, then increment wr_ptr and elem_count.
REQ-023 wr_valid outside LOAD SHALL be ignored, with no write.
REQ-024 When the transfer with wr_ptr = latched count-1 occurs, the next state SHALL be SERVE; load_done SHALL be 1 in that same cycle; wr_ready SHALL be 0 from the next cycle.
REQ-025 In SERVE, every cycle SHALL register rd_data = mem[rd_addr] when rd_addr < elem_count, else 0; rd_valid SHALL be registered as 1. Read latency is exactly 1 cycle.
REQ-026 rd_addr SHALL be treated as unsigned; rd_addr >= elem_count SHALL return 0 with rd_valid=1, giving the zero padding for partial matrices.
REQ-027 In IDLE and LOAD, rd_valid SHALL be 0 and rd_data SHALL be 0 on the following cycle.
REQ-028 A start_load accepted in SERVE SHALL drop rd_valid to 0 from the cycle after acceptance.
REQ-029 Memory SHALL be inferable as simple dual-port RAM: one write port, one synchronous read port. Memory contents need no reset.
REQ-030 Counter arithmetic SHALL be AW+1 bits wide so that a count of FIF0_DEPTH is representable without wrap.

Reset
REQ-031 rst_n=0 SHALL asynchronously force: state=IDLE, wr_ptr=0, elem_count=0, wr_ready=0, rd_valid=0, rd_data=0, load_done=0, load_err=0.
REQ-032 rst_flush=1 at a clock edge SHALL produce the same register values as REQ-031 and override all other inputs that cycle. This includes flush mid-LOAD, where a partially loaded matrix is discarded.
REQ-033 After reset or flush, no rd_valid SHALL assert until a complete load has finished.

Verification
REQ-034 Reset with wr_valid=1 held, then start_load with load_count=16, then stream 0..15 with wr_valid always 1 -> wr_ready is 1 for exactly 16 cycles; load_done pulses with element 15; elem_count=16; rd_addr=5 in SERVE gives rd_data=5 one cycle later with rd_valid=1.
REQ-035 Load 16 elements while toggling wr_valid 1/0 -> exactly 16 writes occur; the memory holds 0..15 in order; load_done fires on the 16th transfer only.
REQ-036 Load 9 elements (3x3), then read rd_addr=8 and rd_addr=200 -> rd_data is the value of element 8 and 0 respectively; rd_valid=1 for both.
REQ-037 start_load with load_count=0, and separately with 257 -> load_err pulses once for each; state stays IDLE; wr_ready stays 0.
REQ-038 Assert rst_flush after 7 of 16 writes -> next cycle state is IDLE and elem_count=0; a following full 16-element load completes normally.
REQ-039 Assert rst_n asynchronously mid-SERVE between clock edges -> rd_valid and rd_data go to 0 immediately, without waiting for a clock edge.
